// File: rtl/regfile_multiport_pkg.sv
// Shared definitions for the multi-port register file: state encoding,
// default geometry and the clog2 helper used by the parameter checks.
package regfile_pkg;

  // Clear engine / array state. CLEAR zeroes one entry per cycle.
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DEF_WIDTH = 32;
  localparam int RF_DEF_DEPTH = 32;
  localparam int RF_DEF_ADDR  = 5;
  localparam int RF_DEF_READ  = 2;

  // Number of address bits needed to index 'value' entries.
  function automatic int rf_clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Bus between the core (decode/writeback/controller) and the register file.
// The core drives requests through 'master'; the register file uses 'slave'.
interface regfile_multiport_if
  import regfile_pkg::*;
#(
  parameter int REG_WIDTH  = RF_DEF_WIDTH,
  parameter int ADDR_WIDTH = RF_DEF_ADDR,
  parameter int NUM_READ   = RF_DEF_READ
) ();

  logic                             write_en;
  logic [ADDR_WIDTH-1:0]            reg_write_addr;
  logic [REG_WIDTH-1:0]             reg_write_data;
  logic [REG_WIDTH/8-1:0]           reg_write_be;
  logic [NUM_READ*ADDR_WIDTH-1:0]   reg_read_addr;
  logic [NUM_READ*REG_WIDTH-1:0]    reg_data_out;
  logic                             clear_req;
  logic                             ready;
  logic                             clear_busy;
  logic                             write_dropped;

  modport master (
    output write_en, reg_write_addr, reg_write_data, reg_write_be,
    output reg_read_addr, clear_req,
    input  reg_data_out, ready, clear_busy, write_dropped
  );

  modport slave (
    input  write_en, reg_write_addr, reg_write_data, reg_write_be,
    input  reg_read_addr, clear_req,
    output reg_data_out, ready, clear_busy, write_dropped
  );

endinterface

// File: rtl/regfile_multiport_byte_merge.sv
// Byte-lane merge: each byte comes from the new word when its enable is set,
// otherwise from the old word. Shared by the write path and the bypass paths.
module regfile_byte_merge
  import regfile_pkg::*;
#(
  parameter int REG_WIDTH = RF_DEF_WIDTH
) (
  input  logic [REG_WIDTH-1:0]   old_data_i,
  input  logic [REG_WIDTH-1:0]   new_data_i,
  input  logic [REG_WIDTH/8-1:0] be_i,
  output logic [REG_WIDTH-1:0]   merged_o
);

  for (genvar gi = 0; gi < REG_WIDTH / 8; gi++) begin : g_byte
    assign merged_o[gi*8 +: 8] = be_i[gi] ? new_data_i[gi*8 +: 8] : old_data_i[gi*8 +: 8];
  end

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file with byte-enabled writes, optional hardwired x0,
// optional write-to-read bypass and a sequential clear engine that zeroes
// one entry per cycle after reset or on request.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int REG_WIDTH  = RF_DEF_WIDTH,
  parameter int REG_DEPTH  = RF_DEF_DEPTH,
  parameter int ADDR_WIDTH = RF_DEF_ADDR,
  parameter int NUM_READ   = RF_DEF_READ,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic                clk_150_mhz,
  input logic                reg_rst_n,
  regfile_multiport_if.slave rf
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_DEPTH - 1);

  // Reject geometries the datapath cannot represent.
  if (REG_WIDTH % 8 != 0) begin : g_bad_width
    $error("regfile_multiport: REG_WIDTH must be a multiple of 8");
  end
  if (REG_DEPTH < 2) begin : g_bad_depth
    $error("regfile_multiport: REG_DEPTH must be at least 2");
  end
  if (ADDR_WIDTH != rf_clog2(REG_DEPTH)) begin : g_bad_addr
    $error("regfile_multiport: ADDR_WIDTH must equal clog2(REG_DEPTH)");
  end
  if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_ports
    $error("regfile_multiport: NUM_READ must be 1..4");
  end

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic                  drop_q, drop_d;
  logic [REG_WIDTH-1:0]  regs_q [REG_DEPTH];

  logic                  wr_in_range;
  logic                  wr_zero_hit;
  logic                  wr_accept;
  logic [REG_WIDTH-1:0]  wr_old;
  logic [REG_WIDTH-1:0]  wr_merged;

  // Addresses past the last entry only exist when the depth is not a power of two.
  if (REG_DEPTH < (1 << ADDR_WIDTH)) begin : g_wr_range
    assign wr_in_range = (rf.reg_write_addr <= LAST_IDX);
  end else begin : g_wr_full
    assign wr_in_range = 1'b1;
  end

  assign wr_zero_hit = (ZERO_REG != 0) && (rf.reg_write_addr == '0);

  // A write lands only in IDLE, when no clear is being requested, and to a
  // writable in-range entry. Everything else counts as dropped.
  assign wr_accept = rf.write_en && (state_q == RF_IDLE) && !rf.clear_req
                     && wr_in_range && !wr_zero_hit;

  assign wr_old = wr_in_range ? regs_q[rf.reg_write_addr] : '0;

  regfile_byte_merge #(
    .REG_WIDTH (REG_WIDTH)
  ) u_wr_merge (
    .old_data_i (wr_old),
    .new_data_i (rf.reg_write_data),
    .be_i       (rf.reg_write_be),
    .merged_o   (wr_merged)
  );

  // Next-state logic for the clear engine and the dropped-write pulse.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    drop_d    = rf.write_en && !wr_accept;
    unique case (state_q)
      RF_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = RF_IDLE;
          clr_idx_d = '0;
        end
      end
      RF_IDLE: begin
        if (rf.clear_req) begin
          state_d   = RF_CLEAR;
          clr_idx_d = '0;
        end
      end
    endcase
  end

  // State register; reset restarts the clear from entry 0.
  always_ff @(posedge clk_150_mhz) begin
    if (!reg_rst_n) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      drop_q    <= drop_d;
    end
  end

  // Array update: the clear engine owns the array while clearing.
  always_ff @(posedge clk_150_mhz) begin
    if (reg_rst_n) begin
      if (state_q == RF_CLEAR) begin
        regs_q[clr_idx_q] <= '0;
      end else if (wr_accept) begin
        regs_q[rf.reg_write_addr] <= wr_merged;
      end
    end
  end

  assign rf.ready         = (state_q == RF_IDLE);
  assign rf.clear_busy    = (state_q == RF_CLEAR);
  assign rf.write_dropped = drop_q;

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_in_range;
    logic [REG_WIDTH-1:0]  rd_stored;
    logic [REG_WIDTH-1:0]  rd_bypass;
    logic [REG_WIDTH-1:0]  rd_data;

    assign rd_addr = rf.reg_read_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

    if (REG_DEPTH < (1 << ADDR_WIDTH)) begin : g_rd_range
      assign rd_in_range = (rd_addr <= LAST_IDX);
    end else begin : g_rd_full
      assign rd_in_range = 1'b1;
    end

    assign rd_stored = rd_in_range ? regs_q[rd_addr] : '0;

    regfile_byte_merge #(
      .REG_WIDTH (REG_WIDTH)
    ) u_byp_merge (
      .old_data_i (rd_stored),
      .new_data_i (rf.reg_write_data),
      .be_i       (rf.reg_write_be),
      .merged_o   (rd_bypass)
    );

    // Read mux: invalid array, x0, out-of-range and bypass hit take priority.
    always_comb begin
      rd_data = rd_stored;
      if (!rf.ready) begin
        rd_data = '0;
      end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd_data = '0;
      end else if (!rd_in_range) begin
        rd_data = '0;
      end else if ((BYPASS != 0) && wr_accept && (rd_addr == rf.reg_write_addr)) begin
        rd_data = rd_bypass;
      end
    end

    assign rf.reg_data_out[gi*REG_WIDTH +: REG_WIDTH] = rd_data;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: three register files (default, no-bypass/no-x0,
// 24-deep) share one stimulus stream. Expected values go into a scoreboard
// queue tagged with the cycle they are due and are compared on the falling edge.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [3:0]  be;
  logic [4:0]  ra0, ra1;
  logic        clr;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_multiport_if #(.REG_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) if_a ();
  regfile_multiport_if #(.REG_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) if_b ();
  regfile_multiport_if #(.REG_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(1)) if_c ();

  assign if_a.write_en = we;  assign if_b.write_en = we;  assign if_c.write_en = we;
  assign if_a.reg_write_addr = wa; assign if_b.reg_write_addr = wa; assign if_c.reg_write_addr = wa;
  assign if_a.reg_write_data = wd; assign if_b.reg_write_data = wd; assign if_c.reg_write_data = wd;
  assign if_a.reg_write_be = be; assign if_b.reg_write_be = be; assign if_c.reg_write_be = be;
  assign if_a.reg_read_addr = {ra1, ra0};
  assign if_b.reg_read_addr = {ra1, ra0};
  assign if_c.reg_read_addr = ra0;
  assign if_a.clear_req = clr; assign if_b.clear_req = clr; assign if_c.clear_req = clr;

  regfile_multiport dut_a (.clk_150_mhz(clk), .reg_rst_n(rst_n), .rf(if_a));
  regfile_multiport #(.ZERO_REG(0), .BYPASS(0)) dut_b (.clk_150_mhz(clk), .reg_rst_n(rst_n), .rf(if_b));
  regfile_multiport #(.REG_DEPTH(24), .NUM_READ(1)) dut_c (.clk_150_mhz(clk), .reg_rst_n(rst_n), .rf(if_c));

  localparam int S_A0 = 0, S_A1 = 1, S_B0 = 2, S_B1 = 3, S_C0 = 4;
  localparam int S_DROP_A = 5, S_DROP_B = 6, S_DROP_C = 7;
  localparam int S_RDY_A = 8, S_BUSY_A = 9, S_RDY_C = 10;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          due;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] a0, a1, b0, b1, c0;
    logic        da, db, dc;
  } vec_t;
  vec_t vecs[13];

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_A0:     return if_a.reg_data_out[31:0];
      S_A1:     return if_a.reg_data_out[63:32];
      S_B0:     return if_b.reg_data_out[31:0];
      S_B1:     return if_b.reg_data_out[63:32];
      S_C0:     return if_c.reg_data_out;
      S_DROP_A: return {31'd0, if_a.write_dropped};
      S_DROP_B: return {31'd0, if_b.write_dropped};
      S_DROP_C: return {31'd0, if_c.write_dropped};
      S_RDY_A:  return {31'd0, if_a.ready};
      S_BUSY_A: return {31'd0, if_a.clear_busy};
      S_RDY_C:  return {31'd0, if_c.ready};
      default:  return 32'hBAD0BAD0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, exp, cyc);
    end else begin
      $display("ok   %s: %08h (cycle %0d)", name, got, cyc);
    end
  endtask

  task automatic expect_at(input string name, input int sel, input logic [31:0] exp, input int delay);
    sb.push_back('{name, sel, exp, cyc + delay});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: compare every entry that falls due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, actual(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  initial begin
    int n;
    int c_n;

    //        we    wa     wd            be     ra0    ra1    a0            a1            b0            b1            c0            da    db    dc
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        4'h0,  5'd5,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 4'hF,  5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 5'd5,  32'h000000AA, 4'h1,  5'd5,  5'd5,  32'hDEADBEAA, 32'hDEADBEAA, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEAA, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        4'h0,  5'd5,  5'd5,  32'hDEADBEAA, 32'hDEADBEAA, 32'hDEADBEAA, 32'hDEADBEAA, 32'hDEADBEAA, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 5'd7,  32'h12345678, 4'hF,  5'd3,  5'd7,  32'h0,        32'h12345678, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        4'h0,  5'd7,  5'd5,  32'h12345678, 32'hDEADBEAA, 32'h12345678, 32'hDEADBEAA, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF,  5'd0,  5'd5,  32'h0,        32'hDEADBEAA, 32'h0,        32'hDEADBEAA, 32'h0,        1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        4'h0,  5'd0,  5'd7,  32'h0,        32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 5'd9,  32'hAABBCCDD, 4'h0,  5'd9,  5'd9,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 5'd9,  32'h11223344, 4'hA,  5'd9,  5'd9,  32'h11003300, 32'h11003300, 32'h0,        32'h0,        32'h11003300, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        4'h0,  5'd9,  5'd2,  32'h11003300, 32'h0,        32'h11003300, 32'h0,        32'h11003300, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 5'd31, 32'hCAFEF00D, 4'hF,  5'd31, 5'd1,  32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 5'd0,  32'h0,        4'h0,  5'd31, 5'd30, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; be = '0; ra0 = '0; ra1 = '0; clr = 1'b0;

    // Reset for three edges, then release.
    repeat (3) step();
    expect_at("rst_ready", S_RDY_A, 32'd0, 0);
    expect_at("rst_busy", S_BUSY_A, 32'd1, 0);
    expect_at("rst_drop", S_DROP_A, 32'd0, 0);
    expect_at("rst_a0", S_A0, 32'd0, 0);
    expect_at("rst_a1", S_A1, 32'd0, 0);
    expect_at("rst_rdy_c", S_RDY_C, 32'd0, 0);
    rst_n = 1'b1;

    // Initial clear: a write at cycle 5 is dropped and pulses at cycle 6 only.
    n = 0; c_n = 0;
    while (!if_a.ready && n < 100) begin
      step();
      n++;
      if (if_c.ready && c_n == 0) c_n = n;
      we = (n == 5);
      wa = 5'd9; wd = 32'h99999999; be = 4'hF;
      if (n == 5) begin
        expect_at("clr_drop_a", S_DROP_A, 32'd1, 1);
        expect_at("clr_drop_b", S_DROP_B, 32'd1, 1);
        expect_at("clr_drop_c", S_DROP_C, 32'd1, 1);
      end
      if (n == 6) expect_at("clr_drop_a_end", S_DROP_A, 32'd0, 1);
      if (n == 10) begin
        expect_at("clr_busy", S_BUSY_A, 32'd1, 0);
        expect_at("clr_read_zero", S_A0, 32'd0, 0);
      end
    end
    we = 1'b0;
    check("init_ready_latency_a", n, 32);
    check("init_ready_latency_c", c_n, 24);

    // Table of single-cycle IDLE vectors.
    for (int i = 0; i < 13; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd; be = vecs[i].be;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      expect_at($sformatf("v%0d_a0", i), S_A0, vecs[i].a0, 0);
      expect_at($sformatf("v%0d_a1", i), S_A1, vecs[i].a1, 0);
      expect_at($sformatf("v%0d_b0", i), S_B0, vecs[i].b0, 0);
      expect_at($sformatf("v%0d_b1", i), S_B1, vecs[i].b1, 0);
      expect_at($sformatf("v%0d_c0", i), S_C0, vecs[i].c0, 0);
      expect_at($sformatf("v%0d_drop_a", i), S_DROP_A, {31'd0, vecs[i].da}, 1);
      expect_at($sformatf("v%0d_drop_b", i), S_DROP_B, {31'd0, vecs[i].db}, 1);
      expect_at($sformatf("v%0d_drop_c", i), S_DROP_C, {31'd0, vecs[i].dc}, 1);
      step();
    end
    we = 1'b0;

    // Clear request together with a write: clear wins, write dropped.
    clr = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h33333333; be = 4'hF; ra0 = 5'd3; ra1 = 5'd5;
    expect_at("creq_a0", S_A0, 32'h0, 0);
    expect_at("creq_a1", S_A1, 32'hDEADBEAA, 0);
    expect_at("creq_drop_a", S_DROP_A, 32'd1, 1);
    expect_at("creq_drop_b", S_DROP_B, 32'd1, 1);
    expect_at("creq_drop_c", S_DROP_C, 32'd1, 1);
    step();
    clr = 1'b0; we = 1'b0;
    expect_at("creq_ready_low", S_RDY_A, 32'd0, 0);
    n = 0; c_n = 0;
    while (!if_a.ready && n < 100) begin
      step();
      n++;
      if (if_c.ready && c_n == 0) c_n = n;
      clr = (n == 3);   // ignored while clearing
    end
    clr = 1'b0;
    check("creq_ready_latency_a", n, 32);
    check("creq_ready_latency_c", c_n, 24);
    ra0 = 5'd3; ra1 = 5'd5;
    expect_at("post_clear_x3_a", S_A0, 32'h0, 0);
    expect_at("post_clear_x5_a", S_A1, 32'h0, 0);
    expect_at("post_clear_x3_b", S_B0, 32'h0, 0);
    expect_at("post_clear_x5_b", S_B1, 32'h0, 0);
    step();

    // Reset at clear index 10: full restart needed before x31 is cleared.
    we = 1'b1; wa = 5'd31; wd = 32'hFFFF0000; be = 4'hF;
    step();
    we = 1'b0; ra0 = 5'd31;
    expect_at("pre_reset_x31", S_A0, 32'hFFFF0000, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    expect_at("midrst_busy", S_BUSY_A, 32'd1, 0);
    n = 0;
    while (!if_a.ready && n < 100) begin
      step();
      n++;
    end
    check("midrst_ready_latency", n, 32);
    ra0 = 5'd31; ra1 = 5'd9;
    expect_at("midrst_x31", S_A0, 32'h0, 0);
    expect_at("midrst_x9", S_A1, 32'h0, 0);
    step();
    step();
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
